// File: rtl/mini_src_datapath_system.sv
// Mini SRC single-bus datapath: register file, PC/IR/MAR/MDR, Y, 64-bit Z, HI/LO, ALU, CON, I/O
// ports and 512x32 memory. Define SYSTEM_MULDIV_EN to build the signed multiplier and divider.
module mini_src_datapath_system #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  HIout,
  input  logic                  LOout,
  input  logic                  Zhi_out,
  input  logic                  Zlo_out,
  input  logic                  PCout,
  input  logic                  MDRout,
  input  logic                  Inport_out,
  input  logic                  Cout,
  input  logic                  Rout,
  input  logic                  BAout,
  input  logic                  MARin,
  input  logic                  Zin,
  input  logic                  PCin,
  input  logic                  MDRin,
  input  logic                  IRin,
  input  logic                  Yin,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic                  CONin,
  input  logic                  Rin,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic [4:0]            opcode,
  input  logic                  IncPC,
  input  logic [DATA_WIDTH-1:0] inport_data,
  input  logic                  inport_data_ready,
  input  logic                  outport_in,
  output logic [DATA_WIDTH-1:0] outport_data,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic                  Mem_enable512x32,
  input  logic                  mem_overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data_in,
  output logic                  con_ff_bit,
  output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
  output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
  output logic [ADDR_WIDTH-1:0] MAR_address_out,
  output logic                  memory_done
);

  localparam int unsigned MemDepth = 1 << ADDR_WIDTH;
  localparam int unsigned ZWidth   = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] rf_q [16];
  logic [DATA_WIDTH-1:0] pc_q, ir_q, mdr_q, y_q, hi_q, lo_q, inport_q, outport_q;
  logic [ADDR_WIDTH-1:0] mar_q;
  logic [ZWidth-1:0]     z_q;
  logic                  con_q;
  logic [DATA_WIDTH-1:0] mem_q [MemDepth];

  logic [3:0]            reg_idx;
  logic [DATA_WIDTH-1:0] bus, c_sext, mem_rdata, mdr_d, sra_res;
  logic [ZWidth-1:0]     z_d, rot_r, rot_l, mul_res, div_res;
  logic [4:0]            shamt;
  logic                  con_d;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  unused_ir;

  assign reg_idx = ({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) | ({4{Grc}} & ir_q[18:15]);
  assign c_sext  = {{(DATA_WIDTH-19){ir_q[18]}}, ir_q[18:0]};
  assign unused_ir = ^ir_q[31:27];

  always_comb begin
    bus = '0;
    if (Rout)            bus = rf_q[reg_idx];
    else if (BAout)      bus = (reg_idx == 4'd0) ? '0 : rf_q[reg_idx];
    else if (HIout)      bus = hi_q;
    else if (LOout)      bus = lo_q;
    else if (Zhi_out)    bus = z_q[ZWidth-1:DATA_WIDTH];
    else if (Zlo_out)    bus = z_q[DATA_WIDTH-1:0];
    else if (PCout)      bus = pc_q;
    else if (MDRout)     bus = mdr_q;
    else if (Inport_out) bus = inport_q;
    else if (Cout)       bus = c_sext;
  end

  // Rotates shift a doubled copy of Y so the wrapped bits fall into the kept half.
  assign shamt   = bus[4:0];
  assign rot_r   = {y_q, y_q} >> shamt;
  assign rot_l   = {y_q, y_q} << shamt;
  assign sra_res = $signed(y_q) >>> shamt;

`ifdef SYSTEM_MULDIV_EN
  logic signed [ZWidth-1:0]     mul_a, mul_b;
  logic signed [DATA_WIDTH-1:0] div_q, div_r;

  assign mul_a   = {{DATA_WIDTH{y_q[DATA_WIDTH-1]}}, y_q};
  assign mul_b   = {{DATA_WIDTH{bus[DATA_WIDTH-1]}}, bus};
  assign mul_res = mul_a * mul_b;

  always_comb begin
    div_q = '0;
    div_r = '0;
    if (bus != '0) begin
      div_q = $signed(y_q) / $signed(bus);
      div_r = $signed(y_q) % $signed(bus);
    end
  end
  assign div_res = {div_r, div_q};
`else
  assign mul_res = '0;
  assign div_res = '0;
`endif

  always_comb begin
    z_d = '0;
    if (IncPC) begin
      z_d[DATA_WIDTH-1:0] = bus + DATA_WIDTH'(1);
    end else begin
      case (opcode)
        5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b01100: z_d[DATA_WIDTH-1:0] = y_q + bus;
        5'b00100:           z_d[DATA_WIDTH-1:0] = y_q - bus;
        5'b00101, 5'b01101: z_d[DATA_WIDTH-1:0] = y_q & bus;
        5'b00110, 5'b01110: z_d[DATA_WIDTH-1:0] = y_q | bus;
        5'b00111:           z_d[DATA_WIDTH-1:0] = y_q >> shamt;
        5'b01000:           z_d[DATA_WIDTH-1:0] = sra_res;
        5'b01001:           z_d[DATA_WIDTH-1:0] = y_q << shamt;
        5'b01010:           z_d[DATA_WIDTH-1:0] = rot_r[DATA_WIDTH-1:0];
        5'b01011:           z_d[DATA_WIDTH-1:0] = rot_l[ZWidth-1:DATA_WIDTH];
        5'b01111:           z_d = mul_res;
        5'b10000:           z_d = div_res;
        5'b10001:           z_d[DATA_WIDTH-1:0] = '0 - bus;
        5'b10010:           z_d[DATA_WIDTH-1:0] = ~bus;
        default:            z_d = '0;
      endcase
    end
  end

  always_comb begin
    case (ir_q[20:19])
      2'b00:   con_d = (bus == '0);
      2'b01:   con_d = (bus != '0);
      2'b10:   con_d = ~bus[DATA_WIDTH-1];
      default: con_d = bus[DATA_WIDTH-1];
    endcase
  end

  assign mem_rdata = mem_q[mar_q];
  assign mdr_d     = Mem_Read ? mem_rdata : bus;

  always_ff @(posedge Clock) begin
    if (clear) begin
      for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      pc_q      <= '0;
      ir_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      y_q       <= '0;
      z_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      con_q     <= 1'b0;
      inport_q  <= '0;
      outport_q <= '0;
    end else begin
      if (Rin)               rf_q[reg_idx] <= bus;
      if (PCin)              pc_q          <= bus;
      if (IRin)              ir_q          <= bus;
      if (MARin)             mar_q         <= bus[ADDR_WIDTH-1:0];
      if (MDRin)             mdr_q         <= mdr_d;
      if (Yin)               y_q           <= bus;
      if (Zin)               z_q           <= z_d;
      if (HIin)              hi_q          <= bus;
      if (LOin)              lo_q          <= bus;
      if (CONin)             con_q         <= con_d;
      if (inport_data_ready) inport_q      <= inport_data;
      if (outport_in)        outport_q     <= bus;
    end
  end

  // Falling-edge write lets a write issued in one cycle be read back by the next rising edge.
  assign mem_we    = Mem_enable512x32 & (mem_overide | Mem_Write);
  assign mem_waddr = mem_overide ? overide_address : mar_q;
  assign mem_wdata = mem_overide ? overide_data_in : mdr_q;

  always_ff @(negedge Clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign outport_data         = outport_q;
  assign con_ff_bit           = con_q;
  assign Mem_to_datapath_out  = mem_rdata;
  assign Mem_data_to_chip_out = mdr_q;
  assign MAR_address_out      = mar_q;
  assign memory_done          = Mem_enable512x32 & (Mem_Read | Mem_Write | mem_overide);

endmodule

// File: tb/tb_mini_src_datapath_system.sv
// Bench for mini_src_datapath_system: directed program plus randomized ALU/register/memory
// traffic checked against a behavioural model of the datapath.
module tb_mini_src_datapath_system;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 9;
`ifdef SYSTEM_MULDIV_EN
  localparam bit MulDiv = 1'b1;
`else
  localparam bit MulDiv = 1'b0;
`endif

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic          clear;
  logic          HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout, Rout, BAout;
  logic          MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, Rin;
  logic          Gra, Grb, Grc, IncPC;
  logic [4:0]    opcode;
  logic [DW-1:0] inport_data;
  logic          inport_data_ready, outport_in;
  logic [DW-1:0] outport_data;
  logic          Mem_Read, Mem_Write, Mem_enable512x32, mem_overide;
  logic [AW-1:0] overide_address;
  logic [DW-1:0] overide_data_in;
  logic          con_ff_bit;
  logic [DW-1:0] Mem_to_datapath_out, Mem_data_to_chip_out;
  logic [AW-1:0] MAR_address_out;
  logic          memory_done;

  mini_src_datapath_system #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clock(Clock), .clear(clear),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out), .PCout(PCout),
    .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout), .Rout(Rout), .BAout(BAout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .Rin(Rin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .opcode(opcode), .IncPC(IncPC),
    .inport_data(inport_data), .inport_data_ready(inport_data_ready),
    .outport_in(outport_in), .outport_data(outport_data),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
    .mem_overide(mem_overide), .overide_address(overide_address),
    .overide_data_in(overide_data_in), .con_ff_bit(con_ff_bit),
    .Mem_to_datapath_out(Mem_to_datapath_out), .Mem_data_to_chip_out(Mem_data_to_chip_out),
    .MAR_address_out(MAR_address_out), .memory_done(memory_done)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_r   [16];
  logic [DW-1:0] m_mem [512];
  logic [AW-1:0] prog_addr [5] = '{9'd0, 9'd1, 9'd3, 9'd4, 9'd6};
  logic [DW-1:0] prog_data [5] = '{32'h0A800000, 32'h9A800001, 32'h9A880001, 32'h9A900001,
                                   32'h9A980001};
  logic [DW-1:0] exp_pc  [4] = '{32'd3, 32'd4, 32'd6, 32'd7};
  logic          exp_con [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  task automatic idle();
    clear = 0; HIout = 0; LOout = 0; Zhi_out = 0; Zlo_out = 0; PCout = 0; MDRout = 0;
    Inport_out = 0; Cout = 0; Rout = 0; BAout = 0; MARin = 0; Zin = 0; PCin = 0; MDRin = 0;
    IRin = 0; Yin = 0; HIin = 0; LOin = 0; CONin = 0; Rin = 0; Gra = 0; Grb = 0; Grc = 0;
    IncPC = 0; opcode = '0; inport_data_ready = 0; outport_in = 0; Mem_Read = 0;
    Mem_Write = 0; Mem_enable512x32 = 0; mem_overide = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic observe(input string tag, input logic [DW-1:0] exp);
    outport_in = 1;
    tick();
    chk(tag, {32'h0, outport_data}, {32'h0, exp});
  endtask

  task automatic put_inport(input logic [DW-1:0] v);
    inport_data = v;
    inport_data_ready = 1;
    tick();
  endtask

  task automatic load_ir(input logic [DW-1:0] v);
    put_inport(v);
    Inport_out = 1; IRin = 1;
    tick();
  endtask

  task automatic set_mar(input logic [AW-1:0] a);
    put_inport({23'h0, a});
    Inport_out = 1; MARin = 1;
    tick();
  endtask

  task automatic mem_ovr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_overide = 1; Mem_enable512x32 = 1; overide_address = a; overide_data_in = d;
    tick();
    m_mem[a] = d;
  endtask

  task automatic rf_write(input logic [3:0] idx, input logic [DW-1:0] v);
    load_ir({5'b0, idx, 23'b0});
    put_inport(v);
    Inport_out = 1; Gra = 1; Rin = 1;
    tick();
    m_r[idx] = v;
  endtask

  task automatic fetch();
    PCout = 1; IncPC = 1; MARin = 1; Zin = 1;
    tick();
    Zlo_out = 1; PCin = 1; MDRin = 1; Mem_Read = 1; Mem_enable512x32 = 1;
    tick();
    MDRout = 1; IRin = 1;
    tick();
  endtask

  task automatic alu_run(input string tag, input logic [4:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic inc, input logic [63:0] exp);
    put_inport(a);
    Inport_out = 1; Yin = 1; inport_data = b; inport_data_ready = 1;
    tick();
    Inport_out = 1; Zin = 1; opcode = op; IncPC = inc;
    tick();
    Zlo_out = 1;
    observe({tag, "_zlo"}, exp[31:0]);
    Zhi_out = 1;
    observe({tag, "_zhi"}, exp[63:32]);
  endtask

  function automatic logic [DW-1:0] sext19(input logic [DW-1:0] ir);
    return {{13{ir[18]}}, ir[18:0]};
  endfunction

  function automatic logic ref_cond(input logic [1:0] c, input logic [DW-1:0] w);
    int s;
    s = w;
    case (c)
      2'd0:    return w == 0;
      2'd1:    return w != 0;
      2'd2:    return s >= 0;
      default: return s < 0;
    endcase
  endfunction

  function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b, input logic inc);
    int unsigned n;
    int          sa, sb;
    longint      prod;
    logic [31:0] lo;
    n  = {27'h0, b[4:0]};
    sa = a;
    sb = b;
    if (inc) return {32'h0, b + 32'd1};
    case (op)
      5'd0, 5'd1, 5'd2, 5'd3, 5'd12: lo = a + b;
      5'd4:         lo = a - b;
      5'd5, 5'd13:  lo = a & b;
      5'd6, 5'd14:  lo = a | b;
      5'd7:         lo = a >> n;
      5'd8:         lo = sa >>> n;
      5'd9:         lo = a << n;
      5'd10:        lo = (n == 0) ? a : ((a >> n) | (a << (32 - n)));
      5'd11:        lo = (n == 0) ? a : ((a << n) | (a >> (32 - n)));
      5'd15: begin
        if (!MulDiv) return 64'h0;
        prod = longint'(sa) * longint'(sb);
        return prod;
      end
      5'd16: begin
        if (!MulDiv || sb == 0) return 64'h0;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      5'd17:        lo = 32'd0 - b;
      5'd18:        lo = ~b;
      default:      lo = 32'h0;
    endcase
    return {32'h0, lo};
  endfunction

  initial begin
    logic [DW-1:0] a, b, v, w;
    logic [4:0]    op;
    logic          inc;
    logic [3:0]    idx;
    logic [AW-1:0] ad;

    idle();
    inport_data = '0; overide_address = '0; overide_data_in = '0;
    clear = 1; tick();
    clear = 1; tick();
    chk("rst_con", con_ff_bit, 0);
    chk("rst_mar", MAR_address_out, 0);
    chk("rst_mdr", Mem_data_to_chip_out, 0);
    chk("rst_outport", outport_data, 0);
    chk("rst_memdone", memory_done, 0);
    PCout = 1;
    observe("rst_pc", 0);

    // Program preload via the override path, with a read-back through MAR.
    mem_overide = 1; Mem_enable512x32 = 1;
    #1 chk("memdone_ovr", memory_done, 1);
    idle();
    for (int i = 0; i < 5; i++) mem_ovr(prog_addr[i], prog_data[i]);
    for (int i = 0; i < 5; i++) begin
      set_mar(prog_addr[i]);
      chk("prog_readback", Mem_to_datapath_out, prog_data[i]);
    end

    // ldi r5,0 from address 0, then the four branches.
    set_mar(0);
    fetch();
    Grb = 1; BAout = 1; Yin = 1; tick();
    Cout = 1; Zin = 1; opcode = 5'b00011; tick();
    Zlo_out = 1; Gra = 1; Rin = 1; tick();
    PCout = 1;
    observe("ldi_pc", 1);
    Gra = 1; Rout = 1;
    observe("ldi_r5", 0);
    for (int k = 0; k < 4; k++) begin
      fetch();
      Gra = 1; Rout = 1; CONin = 1; tick();
      chk("branch_con", con_ff_bit, exp_con[k]);
      PCout = 1; Yin = 1; tick();
      Cout = 1; Zin = 1; opcode = 5'b00011; tick();
      Zlo_out = 1; PCin = con_ff_bit; tick();
      PCout = 1;
      observe("branch_pc", exp_pc[k]);
    end

    // Directed ALU cases.
    alu_run("mul", 5'b01111, 32'd7, 32'hFFFFFFFD, 0, MulDiv ? 64'hFFFFFFFF_FFFFFFEB : 64'h0);
    alu_run("div", 5'b10000, 32'd7, 32'd2, 0, MulDiv ? {32'd1, 32'd3} : 64'h0);
    alu_run("div0", 5'b10000, 32'd9, 32'd0, 0, 64'h0);
    alu_run("ror", 5'b01010, 32'h80000001, 32'd1, 0, 64'hC0000000);
    alu_run("shra", 5'b01000, 32'h80000001, 32'd1, 0, 64'hC0000000);
    alu_run("shr", 5'b00111, 32'h80000001, 32'd1, 0, 64'h40000000);
    alu_run("rol", 5'b01011, 32'h80000001, 32'd1, 0, 64'h00000003);
    alu_run("shl", 5'b01001, 32'h80000001, 32'd1, 0, 64'h00000002);
    alu_run("sub", 5'b00100, 32'd3, 32'd5, 0, 64'hFFFFFFFE);
    alu_run("neg", 5'b10001, 32'd1, 32'd5, 0, 64'hFFFFFFFB);
    alu_run("not", 5'b10010, 32'd1, 32'h0F0F0F0F, 0, 64'hF0F0F0F0);
    alu_run("incpc", 5'b00100, 32'd9, 32'hFFFFFFFF, 1, 64'h0);
    alu_run("badop", 5'b11111, 32'd9, 32'd4, 0, 64'h0);

    // Randomized ALU traffic.
    for (int i = 0; i < 40; i++) begin
      op  = 5'($urandom_range(0, 31));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      inc = ($urandom_range(0, 7) == 0);
      if (op == 5'd16 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      alu_run("alu_rand", op, a, b, inc, ref_alu(op, a, b, inc));
    end

    // Register file: fill every entry, scatter more writes, read back two ways.
    for (int i = 0; i < 16; i++) rf_write(4'(i), $urandom);
    for (int i = 0; i < 12; i++) rf_write(4'($urandom_range(0, 15)), $urandom);
    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      load_ir({13'b0, idx, 15'b0});
      Grc = 1; BAout = 1;
      observe("rf_baout", (idx == 0) ? 32'h0 : m_r[idx]);
      load_ir({9'b0, idx, 19'b0});
      Grb = 1; Rout = 1;
      observe("rf_rout", m_r[idx]);
    end
    load_ir({5'b0, 4'b0101, 4'b1010, 19'b0});
    Gra = 1; Grb = 1; Rout = 1;
    observe("rf_or_sel", m_r[15]);

    // HI/LO and bus priority.
    a = $urandom | 32'h1;
    b = $urandom | 32'h1;
    put_inport(a); Inport_out = 1; HIin = 1; tick();
    put_inport(b); Inport_out = 1; LOin = 1; tick();
    HIout = 1; LOout = 1;
    observe("hi_prio", a);
    LOout = 1;
    observe("lo", b);
    load_ir({5'b0, 4'd3, 23'b0});
    Gra = 1; Rout = 1; HIout = 1; PCout = 1;
    observe("rout_prio", m_r[3]);

    // Sign-extended constant and CON conditions.
    for (int i = 0; i < 12; i++) begin
      v = $urandom;
      w = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      load_ir(v);
      Cout = 1;
      observe("cout_sext", sext19(v));
      put_inport(w);
      Inport_out = 1; CONin = 1; tick();
      chk("con_rand", con_ff_bit, ref_cond(v[20:19], w));
    end

    // Datapath writes through MAR/MDR, and override writes.
    for (int i = 0; i < 6; i++) begin
      ad = AW'($urandom_range(16, 511));
      w  = $urandom;
      set_mar(ad);
      put_inport(w);
      Inport_out = 1; MDRin = 1; tick();
      chk("mdr_load", Mem_data_to_chip_out, w);
      Mem_Write = 1; Mem_enable512x32 = 1;
      #1 chk("memdone_wr", memory_done, 1);
      tick();
      m_mem[ad] = w;
      chk("mem_dp_write", Mem_to_datapath_out, m_mem[ad]);
      put_inport(~w);
      Inport_out = 1; MDRin = 1; tick();
      Mem_Write = 1;
      #1 chk("memdone_noen", memory_done, 0);
      tick();
      chk("mem_no_enable", Mem_to_datapath_out, m_mem[ad]);
      ad = AW'($urandom_range(16, 511));
      mem_ovr(ad, $urandom);
      set_mar(ad);
      chk("mem_ovr_write", Mem_to_datapath_out, m_mem[ad]);
    end

    // Make state non-zero, then clear during a T6-style PC load.
    alu_run("pre_clear", 5'b00000, 32'd1, 32'd1, 0, 64'h2);
    CONin = 1; load_ir(32'h0); CONin = 1; tick();
    chk("pre_clear_con", con_ff_bit, 1);
    Zlo_out = 1; PCin = 1; clear = 1; tick();
    chk("clr_con", con_ff_bit, 0);
    chk("clr_mar", MAR_address_out, 0);
    chk("clr_mdr", Mem_data_to_chip_out, 0);
    chk("clr_outport", outport_data, 0);
    PCout = 1;      observe("clr_pc", 0);
    HIout = 1;      observe("clr_hi", 0);
    LOout = 1;      observe("clr_lo", 0);
    Zhi_out = 1;    observe("clr_zhi", 0);
    Zlo_out = 1;    observe("clr_zlo", 0);
    MDRout = 1;     observe("clr_mdr_bus", 0);
    Inport_out = 1; observe("clr_inport", 0);
    Cout = 1;       observe("clr_ir", 0);
    Zin = 1; opcode = 5'b00000; tick();
    Zlo_out = 1;    observe("clr_y", 0);
    for (int i = 0; i < 16; i++) begin
      load_ir({5'b0, 4'(i), 23'b0});
      Gra = 1; Rout = 1;
      observe("clr_rf", 0);
    end
    for (int i = 0; i < 5; i++) begin
      set_mar(prog_addr[i]);
      chk("clr_mem_kept", Mem_to_datapath_out, m_mem[prog_addr[i]]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
